// File: rtl/i2c_master_defines.sv
// i2c_master_defines: shared bit-controller command encodings, FSM states and default widths
// for the I2C burst byte controller.
package i2c_master_defines;

    localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
    localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

endpackage

// File: rtl/i2c_shift_reg.sv
// i2c_shift_reg: MSB-first word shifter shared by transmit and receive.
// Ports: Clk/Rst_n (async active-low), load (parallel load of din, wins over shift),
// shift (shift left, sin enters at LSB), dout (parallel out; dout MSB is the serial out).
module i2c_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              sin,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)     dout <= '0;
        else if (load)  dout <= din;
        else if (shift) dout <= {dout[DATA_W-2:0], sin};
    end

endmodule

// File: rtl/i2c_master_burst_ctrl.sv
// i2c_master_burst_ctrl: burst byte controller moving Len+1 words of DATA_W bits per command
// through the I2C bit controller.
// Ports: Clk, Rst_n (async active-low); command Start/Stop/Read/Write/Len; transmit Tx_data/Tx_rd;
// receive Rx_data/Rx_valid/Rx_ack; status I2C_done/Al_flag/Busy, I2C_al in; bit controller
// Bit_cmd/Bit_txd out, Bit_ack/Bit_rxd in.
// Optional macro I2C_BURST_TIMEOUT_EN adds parameter TMO_W and output Tmo_flag (bit-command watchdog).
module i2c_master_burst_ctrl
    import i2c_master_defines::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
`ifdef I2C_BURST_TIMEOUT_EN
    ,
    parameter int TMO_W  = 16
`endif
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Read,
    input  logic              Write,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DATA_W-1:0] Tx_data,
    output logic              Tx_rd,
    output logic [DATA_W-1:0] Rx_data,
    output logic              Rx_valid,
    output logic              Rx_ack,
    output logic              I2C_done,
    input  logic              I2C_al,
    output logic              Al_flag,
`ifdef I2C_BURST_TIMEOUT_EN
    output logic              Tmo_flag,
`endif
    output logic              Busy,
    output logic [3:0]        Bit_cmd,
    output logic              Bit_txd,
    input  logic              Bit_ack,
    input  logic              Bit_rxd
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(DATA_W - 1);

    state_t            state, state_n;
    logic [3:0]        cmd_n;
    logic [BC_W-1:0]   bit_cnt, bc_n;
    logic [LEN_W-1:0]  word_cnt, wc_n;
    logic              rd_mode, rd_n, stop_q, stop_n;
    logic [DATA_W-1:0] rx_data_n, sh_q, sh_din;
    logic              rx_ack_n, tx_rd_n, rx_valid_n, done_n, al_n;
    logic              sh_load, sh_shift, enter_rd, enter_wr, burst_end, abort_tmo;

    // The shifter MSB is the transmitted bit; after a read word it is reloaded with the
    // master ACK/NACK so Bit_txd always comes straight from a register.
    i2c_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .load  (sh_load),
        .shift (sh_shift),
        .sin   (Bit_rxd),
        .din   (sh_din),
        .dout  (sh_q)
    );

    assign Bit_txd = sh_q[DATA_W-1];

`ifdef I2C_BURST_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    assign abort_tmo = (state != ST_IDLE) && !Bit_ack && (tmo_cnt == '1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tmo_cnt  <= '0;
            Tmo_flag <= 1'b0;
        end else begin
            tmo_cnt  <= (Bit_ack || Bit_cmd == I2C_CMD_NOP) ? '0 :
                        (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
            Tmo_flag <= abort_tmo && !I2C_al;
        end
    end
`else
    assign abort_tmo = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        cmd_n      = Bit_cmd;
        bc_n       = bit_cnt;
        wc_n       = word_cnt;
        rd_n       = rd_mode;
        stop_n     = stop_q;
        rx_data_n  = Rx_data;
        rx_ack_n   = Rx_ack;
        tx_rd_n    = 1'b0;
        rx_valid_n = 1'b0;
        done_n     = 1'b0;
        al_n       = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        sh_din     = Tx_data;
        enter_rd   = 1'b0;
        enter_wr   = 1'b0;
        burst_end  = 1'b0;
        if (state != ST_IDLE && (I2C_al || abort_tmo)) begin
            // Abort wins over a simultaneous Bit_ack.
            state_n = ST_IDLE;
            cmd_n   = I2C_CMD_NOP;
            done_n  = 1'b1;
            al_n    = I2C_al;
        end else begin
            case (state)
                ST_IDLE: if (Start || Read || Write) begin
                    wc_n   = Len;
                    rd_n   = Read;
                    stop_n = Stop;
                    if (Start) begin
                        state_n = ST_START;
                        cmd_n   = I2C_CMD_START;
                    end
                    enter_rd = !Start && Read;
                    enter_wr = !Start && !Read;
                end
                ST_START: if (Bit_ack) begin
                    enter_rd = rd_mode;
                    enter_wr = !rd_mode;
                end
                ST_WRITE: if (Bit_ack) begin
                    if (bit_cnt == '0) begin
                        state_n = ST_ACK;
                        cmd_n   = I2C_CMD_READ;
                    end else begin
                        sh_shift = 1'b1;
                        bc_n     = bit_cnt - 1'b1;
                    end
                end
                ST_READ: if (Bit_ack) begin
                    if (bit_cnt == '0) begin
                        state_n    = ST_ACK;
                        cmd_n      = I2C_CMD_WRITE;
                        rx_valid_n = 1'b1;
                        rx_data_n  = {sh_q[DATA_W-2:0], Bit_rxd};
                        sh_load    = 1'b1;
                        sh_din     = {word_cnt == '0, {(DATA_W-1){1'b0}}};
                    end else begin
                        sh_shift = 1'b1;
                        bc_n     = bit_cnt - 1'b1;
                    end
                end
                ST_ACK: if (Bit_ack) begin
                    if (!rd_mode) rx_ack_n = Bit_rxd;
                    if (word_cnt == '0 || (!rd_mode && Bit_rxd)) begin
                        burst_end = 1'b1;
                    end else begin
                        wc_n     = word_cnt - 1'b1;
                        enter_rd = rd_mode;
                        enter_wr = !rd_mode;
                    end
                end
                ST_STOP: if (Bit_ack) begin
                    state_n = ST_IDLE;
                    cmd_n   = I2C_CMD_NOP;
                    done_n  = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end
        if (enter_rd) begin
            state_n = ST_READ;
            cmd_n   = I2C_CMD_READ;
            bc_n    = BC_MAX;
        end
        if (enter_wr) begin
            state_n = ST_WRITE;
            cmd_n   = I2C_CMD_WRITE;
            bc_n    = BC_MAX;
            tx_rd_n = 1'b1;
            sh_load = 1'b1;
        end
        if (burst_end) begin
            state_n = stop_q ? ST_STOP : ST_IDLE;
            cmd_n   = stop_q ? I2C_CMD_STOP : I2C_CMD_NOP;
            done_n  = !stop_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            Bit_cmd  <= I2C_CMD_NOP;
            bit_cnt  <= '0;
            word_cnt <= '0;
            rd_mode  <= 1'b0;
            stop_q   <= 1'b0;
            Rx_data  <= '0;
            Rx_ack   <= 1'b0;
            Tx_rd    <= 1'b0;
            Rx_valid <= 1'b0;
            I2C_done <= 1'b0;
            Al_flag  <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_n;
            Bit_cmd  <= cmd_n;
            bit_cnt  <= bc_n;
            word_cnt <= wc_n;
            rd_mode  <= rd_n;
            stop_q   <= stop_n;
            Rx_data  <= rx_data_n;
            Rx_ack   <= rx_ack_n;
            Tx_rd    <= tx_rd_n;
            Rx_valid <= rx_valid_n;
            I2C_done <= done_n;
            Al_flag  <= al_n;
            Busy     <= state_n != ST_IDLE;
        end
    end

endmodule

// File: tb/tb_i2c_master_burst_ctrl.sv
// tb_i2c_master_burst_ctrl: self-checking bench for i2c_master_burst_ctrl with a bit-controller
// model that acks every pending command and a scoreboard of expected bit commands and words.
module tb_i2c_master_burst_ctrl;
    import i2c_master_defines::*;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic              Clk = 1'b0, Rst_n = 1'b0;
    logic              Start = 1'b0, Stop = 1'b0, Read = 1'b0, Write = 1'b0, I2C_al = 1'b0;
    logic              Bit_ack = 1'b0, Bit_rxd = 1'b0;
    logic [LEN_W-1:0]  Len = '0;
    logic [DATA_W-1:0] Tx_data, Rx_data;
    logic              Tx_rd, Rx_valid, Rx_ack, I2C_done, Al_flag, Busy, Bit_txd;
    logic [3:0]        Bit_cmd;
`ifdef I2C_BURST_TIMEOUT_EN
    logic              Tmo_flag;
`endif

    typedef struct packed {
        logic [3:0] cmd;
        logic       chk;
        logic       txd;
    } op_t;

    op_t               exp_q[$], obs_q[$];
    logic              rsp_q[$];
    logic [DATA_W-1:0] rx_exp[$], rx_obs[$];
    logic [DATA_W-1:0] tx_mem[32];
    int vectors = 0, miscompares = 0;
    int ack_cnt = 0, wr_bits = 0, tx_rd_cnt = 0, done_cnt = 0, tx_base = 0;
    bit bfm_on = 1'b0;

    assign Tx_data = tx_mem[(tx_rd_cnt - tx_base) & 31];

    i2c_master_burst_ctrl #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
`ifdef I2C_BURST_TIMEOUT_EN
        ,
        .TMO_W  (4)
`endif
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Stop     (Stop),
        .Read     (Read),
        .Write    (Write),
        .Len      (Len),
        .Tx_data  (Tx_data),
        .Tx_rd    (Tx_rd),
        .Rx_data  (Rx_data),
        .Rx_valid (Rx_valid),
        .Rx_ack   (Rx_ack),
        .I2C_done (I2C_done),
        .I2C_al   (I2C_al),
        .Al_flag  (Al_flag),
`ifdef I2C_BURST_TIMEOUT_EN
        .Tmo_flag (Tmo_flag),
`endif
        .Busy     (Busy),
        .Bit_cmd  (Bit_cmd),
        .Bit_txd  (Bit_txd),
        .Bit_ack  (Bit_ack),
        .Bit_rxd  (Bit_rxd)
    );

    always #5 Clk = ~Clk;

    // Bit controller model: completes each pending command with a one-cycle ack, logging it.
    always @(negedge Clk) begin
        if (Bit_ack) begin
            Bit_ack = 1'b0;
        end else if (bfm_on && Bit_cmd != I2C_CMD_NOP) begin
            obs_q.push_back(op_t'({Bit_cmd, 1'b0, Bit_txd}));
            Bit_rxd = (rsp_q.size() != 0) ? rsp_q.pop_front() : 1'b0;
            ack_cnt++;
            if (Bit_cmd == I2C_CMD_WRITE) wr_bits++;
            Bit_ack = 1'b1;
        end
    end

    always @(negedge Clk) begin
        if (Tx_rd) tx_rd_cnt++;
        if (Rx_valid) rx_obs.push_back(Rx_data);
        if (I2C_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_op(input logic [3:0] c, input logic k, input logic t, input logic r);
        exp_q.push_back(op_t'({c, k, t}));
        rsp_q.push_back(r);
    endtask

    task automatic push_write_word(input logic [DATA_W-1:0] w, input logic slave_ack);
        for (int i = DATA_W - 1; i >= 0; i--) push_op(I2C_CMD_WRITE, 1'b1, w[i], 1'b0);
        push_op(I2C_CMD_READ, 1'b0, 1'b0, slave_ack);
    endtask

    task automatic push_read_word(input logic [DATA_W-1:0] w, input logic nack);
        for (int i = DATA_W - 1; i >= 0; i--) push_op(I2C_CMD_READ, 1'b0, 1'b0, w[i]);
        push_op(I2C_CMD_WRITE, 1'b1, nack, 1'b0);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        rsp_q.delete();
        rx_exp.delete();
        rx_obs.delete();
        tx_base = tx_rd_cnt;
    endtask

    task automatic issue(input logic s, input logic p, input logic r, input logic w,
                         input logic [LEN_W-1:0] l);
        Start = s; Stop = p; Read = r; Write = w; Len = l;
        tick();
        Start = 1'b0; Stop = 1'b0; Read = 1'b0; Write = 1'b0;
    endtask

    task automatic wait_done(input int base, input int lim, output bit ok);
        int n = 0;
        while (done_cnt == base && n < lim) begin
            tick();
            n++;
        end
        ok = (done_cnt != base);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if ({Bit_cmd, Bit_txd, Tx_rd, Rx_valid, Rx_ack, I2C_done, Al_flag, Busy} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_in: outputs=%h want 000", {Bit_cmd, Bit_txd, Tx_rd, Rx_valid, Rx_ack, I2C_done, Al_flag, Busy});
        end
        Rst_n = 1'b1;
        tick();
        vectors++;
        if ({Bit_cmd, Bit_txd, Tx_rd, Rx_valid, Rx_ack, I2C_done, Al_flag, Busy, Rx_data} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset_out: outputs=%h rx=%h want 0", {Bit_cmd, Bit_txd, Busy}, Rx_data);
        end
    endtask

    task automatic test_write_burst();
        int b, t, n;
        bit ok;
        op_t e, o;
        clear_queues();
        tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'hFF;
        push_op(I2C_CMD_START, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_write_word(tx_mem[i], 1'b0);
        push_op(I2C_CMD_STOP, 1'b0, 1'b0, 1'b0);
        b = done_cnt; t = tx_rd_cnt; bfm_on = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
        repeat (6) tick();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        wait_done(b, 200, ok);
        tick();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL wr_done_timeout: no I2C_done within 200 cycles"); end
        n = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : op_t'(7'h7f);
            vectors++;
            if (o.cmd !== e.cmd || (e.chk && o.txd !== e.txd)) begin
                miscompares++;
                $display("FAIL wr_op%0d: got cmd=%h txd=%b want cmd=%h txd=%b", n, o.cmd, o.txd, e.cmd, e.txd);
            end
            n++;
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL wr_extra_ops: %0d extra want 0", obs_q.size()); end
        vectors++;
        if (tx_rd_cnt - t != 3) begin miscompares++; $display("FAIL wr_tx_rd: got %0d want 3", tx_rd_cnt - t); end
        vectors++;
        if (done_cnt - b != 1) begin miscompares++; $display("FAIL wr_done_cnt: got %0d want 1", done_cnt - b); end
        vectors++;
        if ({Rx_ack, Al_flag, Busy, Bit_cmd} !== 7'h0) begin
            miscompares++;
            $display("FAIL wr_status: rx_ack=%b al=%b busy=%b cmd=%h want 0", Rx_ack, Al_flag, Busy, Bit_cmd);
        end
    endtask

    task automatic test_read_burst();
        int b, n;
        bit ok;
        op_t e, o;
        logic [DATA_W-1:0] w;
        clear_queues();
        push_read_word(8'h5A, 1'b0);
        push_read_word(8'hC3, 1'b1);
        rx_exp.push_back(8'h5A);
        rx_exp.push_back(8'hC3);
        b = done_cnt; bfm_on = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        wait_done(b, 200, ok);
        tick();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rd_done_timeout: no I2C_done within 200 cycles"); end
        n = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : op_t'(7'h7f);
            vectors++;
            if (o.cmd !== e.cmd || (e.chk && o.txd !== e.txd)) begin
                miscompares++;
                $display("FAIL rd_op%0d: got cmd=%h txd=%b want cmd=%h txd=%b", n, o.cmd, o.txd, e.cmd, e.txd);
            end
            n++;
        end
        while (rx_exp.size() != 0) begin
            w = rx_exp.pop_front();
            vectors++;
            if (rx_obs.size() == 0) begin
                miscompares++;
                $display("FAIL rd_word: got none want %h", w);
            end else if (rx_obs[0] !== w) begin
                miscompares++;
                $display("FAIL rd_word: got %h want %h", rx_obs[0], w);
                void'(rx_obs.pop_front());
            end else begin
                void'(rx_obs.pop_front());
            end
        end
        vectors++;
        if (rx_obs.size() != 0 || done_cnt - b != 1) begin
            miscompares++;
            $display("FAIL rd_counts: extra_rx=%0d done=%0d want 0 and 1", rx_obs.size(), done_cnt - b);
        end
    endtask

    task automatic test_nack();
        int b, t, n;
        bit ok;
        op_t e, o;
        clear_queues();
        tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_mem[2] = 8'h33; tx_mem[3] = 8'h44;
        push_op(I2C_CMD_START, 1'b0, 1'b0, 1'b0);
        push_write_word(8'h11, 1'b0);
        push_write_word(8'h22, 1'b1);
        push_op(I2C_CMD_STOP, 1'b0, 1'b0, 1'b0);
        b = done_cnt; t = tx_rd_cnt; bfm_on = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        wait_done(b, 200, ok);
        tick();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL nack_done_timeout: no I2C_done within 200 cycles"); end
        n = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : op_t'(7'h7f);
            vectors++;
            if (o.cmd !== e.cmd || (e.chk && o.txd !== e.txd)) begin
                miscompares++;
                $display("FAIL nack_op%0d: got cmd=%h txd=%b want cmd=%h txd=%b", n, o.cmd, o.txd, e.cmd, e.txd);
            end
            n++;
        end
        vectors++;
        if (obs_q.size() != 0 || tx_rd_cnt - t != 2 || done_cnt - b != 1) begin
            miscompares++;
            $display("FAIL nack_counts: extra=%0d tx_rd=%0d done=%0d want 0,2,1", obs_q.size(), tx_rd_cnt - t, done_cnt - b);
        end
        vectors++;
        if (Rx_ack !== 1'b1) begin miscompares++; $display("FAIL nack_rx_ack: got %b want 1", Rx_ack); end
    endtask

    task automatic test_arb_lost();
        int a, b, n;
        op_t e, o;
        clear_queues();
        tx_mem[0] = 8'hB6;
        for (int i = DATA_W - 1; i >= DATA_W - 5; i--) push_op(I2C_CMD_WRITE, 1'b1, tx_mem[0][i], 1'b0);
        a = ack_cnt; b = done_cnt; bfm_on = 1'b1;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        n = 0;
        while (ack_cnt - a < 5 && n < 50) begin
            tick();
            n++;
        end
        bfm_on = 1'b0;
        I2C_al = 1'b1;
        tick();
        I2C_al = 1'b0;
        vectors++;
        if (ack_cnt - a != 5) begin miscompares++; $display("FAIL al_bits: got %0d acks want 5", ack_cnt - a); end
        vectors++;
        if ({Bit_cmd, Busy, I2C_done, Al_flag} !== {I2C_CMD_NOP, 3'b011}) begin
            miscompares++;
            $display("FAIL al_abort: cmd=%h busy=%b done=%b al=%b want 0 0 1 1", Bit_cmd, Busy, I2C_done, Al_flag);
        end
        n = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : op_t'(7'h7f);
            vectors++;
            if (o.cmd !== e.cmd || o.txd !== e.txd) begin
                miscompares++;
                $display("FAIL al_op%0d: got cmd=%h txd=%b want cmd=%h txd=%b", n, o.cmd, o.txd, e.cmd, e.txd);
            end
            n++;
        end
        tick();
        vectors++;
        if (I2C_done !== 1'b0 || Al_flag !== 1'b0 || done_cnt - b != 1) begin
            miscompares++;
            $display("FAIL al_pulse: done=%b al=%b count=%0d want 0 0 1", I2C_done, Al_flag, done_cnt - b);
        end
    endtask

    task automatic test_long_burst_and_reset();
        int b, t, wb, n;
        bit ok;
        op_t e, o;
        clear_queues();
        for (int i = 0; i < 16; i++) begin
            tx_mem[i] = DATA_W'(i * 17 + 3);
            push_write_word(tx_mem[i], 1'b0);
        end
        b = done_cnt; t = tx_rd_cnt; wb = wr_bits; bfm_on = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        wait_done(b, 400, ok);
        tick();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL long_done_timeout: no I2C_done within 400 cycles"); end
        n = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : op_t'(7'h7f);
            vectors++;
            if (o.cmd !== e.cmd || (e.chk && o.txd !== e.txd)) begin
                miscompares++;
                $display("FAIL long_op%0d: got cmd=%h txd=%b want cmd=%h txd=%b", n, o.cmd, o.txd, e.cmd, e.txd);
            end
            n++;
        end
        vectors++;
        if (wr_bits - wb != 128) begin miscompares++; $display("FAIL long_bits: got %0d want 128", wr_bits - wb); end
        vectors++;
        if (tx_rd_cnt - t != 16 || done_cnt - b != 1) begin
            miscompares++;
            $display("FAIL long_counts: tx_rd=%0d done=%0d want 16 1", tx_rd_cnt - t, done_cnt - b);
        end
        clear_queues();
        b = done_cnt;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        repeat (20) tick();
        vectors++;
        if (Busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", Busy); end
        bfm_on = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        vectors++;
        if ({Bit_cmd, Bit_txd, Tx_rd, Rx_valid, Rx_ack, I2C_done, Al_flag, Busy, Rx_data} !== 19'h0) begin
            miscompares++;
            $display("FAIL async_reset: cmd=%h txd=%b busy=%b rx=%h want 0", Bit_cmd, Bit_txd, Busy, Rx_data);
        end
        repeat (3) tick();
        Rst_n = 1'b1;
        repeat (2) tick();
        vectors++;
        if (done_cnt != b || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: done=%0d busy=%b want 0 0", done_cnt - b, Busy);
        end
        clear_queues();
    endtask

`ifdef I2C_BURST_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        clear_queues();
        tx_mem[0] = 8'h81;
        bfm_on = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        n = 0;
        while (!I2C_done && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 16 || Tmo_flag !== 1'b1 || Al_flag !== 1'b0 || Bit_cmd !== I2C_CMD_NOP) begin
            miscompares++;
            $display("FAIL timeout: cycles=%0d tmo=%b al=%b cmd=%h want 16 1 0 0", n, Tmo_flag, Al_flag, Bit_cmd);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_nack();
        test_arb_lost();
        test_long_burst_and_reset();
`ifdef I2C_BURST_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_master_burst_ctrl.md
Name: i2c_master_burst_ctrl

Overview:
Parametrised successor byte controller for the I2C master: it moves a burst of 1..2^LEN_W words of DATA_W bits per command, instead of a single byte. It holds the shift register internally. It drives the existing bit controller through Bit_cmd/Bit_txd/Bit_ack/Bit_rxd and sits between the register file (command/data registers) and that bit controller.

Parameters:
DATA_W, 8, bits per word shifted MSB-first.
LEN_W, 4, width of burst-length field; burst = Len+1 words.

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Start  in  1  generate START (or repeated START) before data phase
Stop  in  1  generate STOP after final acknowledge
Read  in  1  read burst (priority over Write)
Write  in  1  write burst
Len  in  LEN_W  burst length minus one, sampled at command accept
Tx_data  in  DATA_W  next word to transmit
Tx_rd  out  1  one-cycle pulse: Tx_data consumed (loaded into shifter)
Rx_data  out  DATA_W  last received word
Rx_valid  out  1  one-cycle pulse: Rx_data updated
Rx_ack  out  1  slave acknowledge of last written word (0=ACK)
I2C_done  out  1  one-cycle pulse: command finished (normal or abort)
I2C_al  in  1  arbitration lost from bit controller
Al_flag  out  1  one-cycle pulse with I2C_done when aborted by I2C_al
Busy  out  1  high whenever state != IDLE
Bit_cmd  out  4  command to bit controller (I2C_CMD_* encodings)
Bit_txd  out  1  bit to transmit
Bit_ack  in  1  bit command complete
Bit_rxd  in  1  received bit

Behaviour:
- Reset: state IDLE; Bit_cmd=I2C_CMD_NOP; Bit_txd=0; Tx_rd, Rx_valid, I2C_done, Al_flag = 0; Rx_ack=0; Rx_data=0; counters 0. All outputs are registered.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE: on Start|Read|Write, latch Len into word counter and Read/Write mode. Next cycle: Bit_cmd = START if Start, else READ/WRITE.
- Write mode: a word is loaded with a Tx_rd pulse on entry to WRITE. Bit_txd = shifter MSB. The bit counter is set to DATA_W-1.
- Command hold: each Bit_cmd is held until Bit_ack. On the Bit_ack cycle the next command is registered, so the new command appears on the following edge. There is no NOP gap between bits.
- START + Bit_ack: go to READ or WRITE.
- WRITE, per Bit_ack: shift and decrement the bit counter. At count 0, go to ACK and issue READ for the slave ack bit.
- READ, per Bit_ack: shift in Bit_rxd. At count 0, go to ACK, pulse Rx_valid with the full word, and issue WRITE. Bit_txd = 1 (NACK) if this is the last word, else 0.
- ACK + Bit_ack, write mode: Rx_ack <= Bit_rxd.
  - If Bit_rxd=1 (NACK), abort the remaining words.
  - Else, if more words remain: decrement the word counter, Tx_rd, reload, back to WRITE.
- ACK + Bit_ack, read mode: if more words remain, back to READ.
- Burst end (last word or NACK abort): if Stop, go to STOP with Bit_cmd=STOP. Else go to IDLE with Bit_cmd=NOP and pulse I2C_done.
- STOP + Bit_ack: go to IDLE, Bit_cmd=NOP, pulse I2C_done.
- I2C_al in any non-IDLE state: same cycle decision. Next edge gives state IDLE, Bit_cmd=NOP, I2C_done=1, Al_flag=1. I2C_al has priority over Bit_ack.
- Command inputs are ignored while Busy. Len=0 gives a single word. Len=all-ones gives 2^LEN_W words; the word counter must not wrap early.
- Asynchronous reset mid-burst returns to reset values immediately. No I2C_done is generated.

Optional Feature:
- Macro I2C_BURST_TIMEOUT_EN adds a parameter TMO_W (default 16) and output Tmo_flag.
- With the macro: a watchdog counts cycles while Bit_cmd != NOP and Bit_ack=0. It resets on every Bit_ack. Reaching all-ones aborts exactly like arbitration loss, but pulses Tmo_flag instead of Al_flag.
- Without the macro: no counter, no port; a stalled bit controller holds the FSM indefinitely.

Decomposition:
- Shared package/defines i2c_master_defines: I2C_CMD_NOP/START/STOP/WRITE/READ encodings, FSM state encodings, default DATA_W/LEN_W.
- Sub-module i2c_shift_reg (parameter DATA_W): load, shift, serial-in, serial-out, parallel-out.

Test Plan:
1. Write, Start+Stop, Len=2, words 0xA5,0x3C,0xFF, slave ACKs: sequence START, 24 WRITE bits MSB-first, 3 ack READs, STOP. 3 Tx_rd pulses, I2C_done once, Rx_ack=0.
2. Read, Len=1, Bit_rxd pattern 0x5A then 0xC3: Rx_valid twice with those values. Master ack bits are 0 then 1 (NACK last).
3. Write Len=3 with slave NACK on word 1: Rx_ack=1, only 2 Tx_rd, STOP issued, I2C_done pulse.
4. I2C_al on bit 5 of a write: next edge Bit_cmd=NOP, state IDLE, I2C_done=Al_flag=1, Busy=0.
5. Len=15, DATA_W=8: exactly 128 data bits, 16 Tx_rd. Then Rst_n low mid-burst: all outputs return to reset values asynchronously.
6. With I2C_BURST_TIMEOUT_EN, TMO_W=4, Bit_ack held 0: abort after 15 cycles with Tmo_flag=1 and I2C_done=1.
